// File: rtl/voice_alloc.sv
// voice_alloc: polyphonic note allocator feeding the voice array.
// Accepts note-on/note-off events over valid/ready. For each event it
// retriggers a voice already playing the note, takes the lowest free voice,
// or steals the oldest voice. Per-voice age is kept as a rank permutation:
// rank 0 is the oldest assignment and NVOICES-1 the newest. Retrigger and
// steal hold the target's gate low for GAP cycles so the envelope sees a
// fresh rising edge.
module voice_alloc #(
  parameter int NVOICES = 4,
  parameter int GAP     = 4
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   ev_valid,
  output logic                   ev_ready,
  input  logic                   ev_on,
  input  logic [6:0]             ev_note,
  input  logic                   panic,
  output logic [7*NVOICES-1:0]   F_in,
  output logic [NVOICES-1:0]     key_on,
  output logic                   steal
);

  localparam int RW = (NVOICES > 1) ? $clog2(NVOICES) : 1;
  localparam int CW = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DECIDE = 2'd1;
  localparam logic [1:0] S_GAP    = 2'd2;

  // State registers and their next-state values
  logic [1:0]                 state_q,   state_d;
  logic [NVOICES-1:0]         held_q,    held_d;
  logic [NVOICES-1:0][6:0]    note_q,    note_d;
  logic [NVOICES-1:0][RW-1:0] rank_q,    rank_d;
  logic                       ev_on_q,   ev_on_d;
  logic [6:0]                 ev_note_q, ev_note_d;
  logic [RW-1:0]              target_q,  target_d;
  logic [CW-1:0]              gap_cnt_q, gap_cnt_d;
  logic                       steal_q,   steal_d;
  logic [NVOICES-1:0]         key_on_q,  key_on_d;

  // Decision helpers
  logic                       match_found_s;
  logic [RW-1:0]              match_idx_s;
  logic                       free_found_s;
  logic [RW-1:0]              free_idx_s;
  logic [RW-1:0]              oldest_idx_s;
  logic [RW-1:0]              chosen_s;
  logic [RW-1:0]              old_rank_s;
  logic                       use_gap_s;
  logic [NVOICES-1:0]         gap_mask_s;

  // One-hot decode of a voice index
  function automatic logic [NVOICES-1:0] onehot(input logic [RW-1:0] idx);
    logic [NVOICES-1:0] v;
    v = {NVOICES{1'b0}};
    for (int i = 0; i < NVOICES; i++) begin
      if (RW'(i) == idx) begin
        v[i] = 1'b1;
      end else begin
        v[i] = 1'b0;
      end
    end
    return v;
  endfunction

  assign ev_ready = Reset & (state_q == S_IDLE) & ~panic;
  assign F_in     = note_q;
  assign key_on   = key_on_q;
  assign steal    = steal_q;

  // Search held notes for a match, the lowest free voice and the oldest voice
  always_comb begin
    match_found_s = 1'b0;
    match_idx_s   = {RW{1'b0}};
    free_found_s  = 1'b0;
    free_idx_s    = {RW{1'b0}};
    oldest_idx_s  = {RW{1'b0}};
    // Descending scan so the lowest index wins when several qualify
    for (int i = NVOICES - 1; i >= 0; i--) begin
      if (held_q[i] && (note_q[i] == ev_note_q)) begin
        match_found_s = 1'b1;
        match_idx_s   = RW'(i);
      end else begin
        match_found_s = match_found_s;
      end
      if (!held_q[i]) begin
        free_found_s = 1'b1;
        free_idx_s   = RW'(i);
      end else begin
        free_found_s = free_found_s;
      end
      if (rank_q[i] == {RW{1'b0}}) begin
        oldest_idx_s = RW'(i);
      end else begin
        oldest_idx_s = oldest_idx_s;
      end
    end
  end

  // Event acceptance, allocation decision, gap timing and panic override
  always_comb begin
    state_d    = state_q;
    held_d     = held_q;
    note_d     = note_q;
    rank_d     = rank_q;
    ev_on_d    = ev_on_q;
    ev_note_d  = ev_note_q;
    target_d   = target_q;
    gap_cnt_d  = gap_cnt_q;
    steal_d    = 1'b0;
    chosen_s   = {RW{1'b0}};
    old_rank_s = {RW{1'b0}};
    use_gap_s  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ev_valid && ev_ready) begin
          ev_on_d   = ev_on;
          ev_note_d = ev_note;
          state_d   = S_DECIDE;
        end else begin
          state_d   = S_IDLE;
        end
      end

      S_DECIDE: begin
        if (ev_on_q) begin
          if (match_found_s) begin
            chosen_s  = match_idx_s;
            use_gap_s = 1'b1;
          end else if (free_found_s) begin
            chosen_s  = free_idx_s;
            use_gap_s = 1'b0;
          end else begin
            chosen_s  = oldest_idx_s;
            use_gap_s = 1'b1;
            steal_d   = 1'b1;
          end
          old_rank_s = rank_q[chosen_s];
          held_d[chosen_s] = 1'b1;
          note_d[chosen_s] = ev_note_q;
          // Chosen voice becomes newest; younger voices each age by one
          for (int i = 0; i < NVOICES; i++) begin
            if (RW'(i) == chosen_s) begin
              rank_d[i] = RW'(NVOICES - 1);
            end else if (rank_q[i] > old_rank_s) begin
              rank_d[i] = rank_q[i] - RW'(1);
            end else begin
              rank_d[i] = rank_q[i];
            end
          end
          if (use_gap_s) begin
            state_d   = S_GAP;
            target_d  = chosen_s;
            gap_cnt_d = CW'(GAP - 1);
          end else begin
            state_d   = S_IDLE;
          end
        end else begin
          // Note-off releases every held voice on that note; note and rank stay
          for (int i = 0; i < NVOICES; i++) begin
            if (held_q[i] && (note_q[i] == ev_note_q)) begin
              held_d[i] = 1'b0;
            end else begin
              held_d[i] = held_q[i];
            end
          end
          state_d = S_IDLE;
        end
      end

      S_GAP: begin
        if (gap_cnt_q == {CW{1'b0}}) begin
          state_d   = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - CW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Panic silences everything and drops any pending decision
    if (panic) begin
      held_d  = {NVOICES{1'b0}};
      note_d  = note_q;
      rank_d  = rank_q;
      steal_d = 1'b0;
      state_d = S_IDLE;
    end else begin
      state_d = state_d;
    end
  end

  // Gate output follows next-cycle hold state masked by an active gap
  always_comb begin
    if (state_d == S_GAP) begin
      gap_mask_s = onehot(target_d);
    end else begin
      gap_mask_s = {NVOICES{1'b0}};
    end
    key_on_d = held_d & ~gap_mask_s;
  end

  // State update with synchronous active-low reset
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q   <= S_IDLE;
      held_q    <= {NVOICES{1'b0}};
      note_q    <= '0;
      for (int i = 0; i < NVOICES; i++) begin
        rank_q[i] <= RW'(i);
      end
      ev_on_q   <= 1'b0;
      ev_note_q <= 7'd0;
      target_q  <= {RW{1'b0}};
      gap_cnt_q <= {CW{1'b0}};
      steal_q   <= 1'b0;
      key_on_q  <= {NVOICES{1'b0}};
    end else begin
      state_q   <= state_d;
      held_q    <= held_d;
      note_q    <= note_d;
      rank_q    <= rank_d;
      ev_on_q   <= ev_on_d;
      ev_note_q <= ev_note_d;
      target_q  <= target_d;
      gap_cnt_q <= gap_cnt_d;
      steal_q   <= steal_d;
      key_on_q  <= key_on_d;
    end
  end

endmodule

// File: tb/tb_voice_alloc.sv
// Directed bench for voice_alloc (NVOICES=4, GAP=4). Expected output
// snapshots are queued with the cycle they are due and compared there.
module tb_voice_alloc;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        ev_valid;
  logic        ev_ready;
  logic        ev_on;
  logic [6:0]  ev_note;
  logic        panic;
  logic [27:0] F_in;
  logic [3:0]  key_on;
  logic        steal;

  int cyc;
  int n_cmp;
  int n_fail;

  typedef struct {
    int          due;
    string       tag;
    logic [27:0] f;
    logic [3:0]  k;
    logic        s;
    logic        r;
  } exp_t;

  exp_t sb[$];

  voice_alloc #(.NVOICES(4), .GAP(4)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_on    (ev_on),
    .ev_note  (ev_note),
    .panic    (panic),
    .F_in     (F_in),
    .key_on   (key_on),
    .steal    (steal)
  );

  always #5 Clk = ~Clk;

  function automatic logic [27:0] pk(input logic [6:0] a3, input logic [6:0] a2,
                                     input logic [6:0] a1, input logic [6:0] a0);
    return {a3, a2, a1, a0};
  endfunction

  task automatic expect_at(input int due, input string tag, input logic [27:0] f,
                           input logic [3:0] k, input logic s, input logic r);
    exp_t e;
    e.due = due; e.tag = tag; e.f = f; e.k = k; e.s = s; e.r = r;
    sb.push_back(e);
  endtask

  task automatic check_due();
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        n_cmp += 4;
        assert (F_in === sb[i].f) else begin
          n_fail++; $error("FAIL %s F_in observed %h expected %h", sb[i].tag, F_in, sb[i].f);
        end
        assert (key_on === sb[i].k) else begin
          n_fail++; $error("FAIL %s key_on observed %b expected %b", sb[i].tag, key_on, sb[i].k);
        end
        assert (steal === sb[i].s) else begin
          n_fail++; $error("FAIL %s steal observed %b expected %b", sb[i].tag, steal, sb[i].s);
        end
        assert (ev_ready === sb[i].r) else begin
          n_fail++; $error("FAIL %s ev_ready observed %b expected %b", sb[i].tag, ev_ready, sb[i].r);
        end
        sb.delete(i);
      end else if (sb[i].due < cyc) begin
        n_cmp++; n_fail++;
        $display("FAIL %s not checked at cycle %0d (now %0d)", sb[i].tag, sb[i].due, cyc);
        sb.delete(i);
      end
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
    cyc++;
    check_due();
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic present(input logic on, input logic [6:0] n, output int t);
    int guard;
    guard = 0;
    while (ev_ready !== 1'b1 && guard < 64) begin
      tick();
      guard++;
    end
    n_cmp++;
    assert (ev_ready === 1'b1) else begin
      n_fail++; $error("FAIL ready_wait observed %b expected 1", ev_ready);
    end
    ev_valid = 1'b1;
    ev_on    = on;
    ev_note  = n;
    t        = cyc;
  endtask

  task automatic accept();
    tick();
    ev_valid = 1'b0;
  endtask

  task automatic check_rank(input string tag, input logic [7:0] exp_rank);
    logic [7:0] obs;
    logic [3:0] seen;
    obs  = dut.rank_q;
    seen = 4'd0;
    for (int i = 0; i < 4; i++) seen[obs[2*i +: 2]] = 1'b1;
    n_cmp += 2;
    assert (obs === exp_rank) else begin
      n_fail++; $error("FAIL %s rank observed %h expected %h", tag, obs, exp_rank);
    end
    assert (seen === 4'hF) else begin
      n_fail++; $error("FAIL %s rank_perm observed %b expected 1111", tag, seen);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int p;
    logic [27:0] full;
    Reset = 1'b0; ev_valid = 1'b0; ev_on = 1'b0; ev_note = 7'd0; panic = 1'b0;
    cyc = 0; n_cmp = 0; n_fail = 0;

    // Reset state
    expect_at(2, "reset", 28'd0, 4'b0000, 1'b0, 1'b0);
    tick(); tick();
    check_rank("reset_rank", 8'hE4);
    Reset = 1'b1;
    expect_at(3, "post_reset", 28'd0, 4'b0000, 1'b0, 1'b1);
    tick();

    // Fill voices 0..3 in order
    present(1'b1, 7'd60, t);
    expect_at(t + 1, "on60_decide", 28'd0, 4'b0000, 1'b0, 1'b0);
    expect_at(t + 2, "on60", pk(7'd0, 7'd0, 7'd0, 7'd60), 4'b0001, 1'b0, 1'b1);
    accept(); tick();
    check_rank("on60_rank", 8'h93);

    present(1'b1, 7'd64, t);
    expect_at(t + 2, "on64", pk(7'd0, 7'd0, 7'd64, 7'd60), 4'b0011, 1'b0, 1'b1);
    accept(); tick();
    check_rank("on64_rank", 8'h4E);

    present(1'b1, 7'd67, t);
    expect_at(t + 2, "on67", pk(7'd0, 7'd67, 7'd64, 7'd60), 4'b0111, 1'b0, 1'b1);
    accept(); tick();
    check_rank("on67_rank", 8'h39);

    present(1'b1, 7'd71, t);
    expect_at(t + 2, "on71", pk(7'd71, 7'd67, 7'd64, 7'd60), 4'b1111, 1'b0, 1'b1);
    accept(); tick();
    check_rank("on71_rank", 8'hE4);

    // Steal the oldest voice (0)
    full = pk(7'd71, 7'd67, 7'd64, 7'd72);
    present(1'b1, 7'd72, t);
    expect_at(t + 2, "steal72_t2", full, 4'b1110, 1'b1, 1'b0);
    expect_at(t + 3, "steal72_t3", full, 4'b1110, 1'b0, 1'b0);
    expect_at(t + 5, "steal72_t5", full, 4'b1110, 1'b0, 1'b0);
    expect_at(t + 6, "steal72_end", full, 4'b1111, 1'b0, 1'b1);
    accept(); tick();
    check_rank("steal72_rank", 8'h93);
    wait_to(t + 6);

    // Retrigger voice 1 (64)
    present(1'b1, 7'd64, t);
    expect_at(t + 2, "retrig64_t2", full, 4'b1101, 1'b0, 1'b0);
    expect_at(t + 5, "retrig64_t5", full, 4'b1101, 1'b0, 1'b0);
    expect_at(t + 6, "retrig64_end", full, 4'b1111, 1'b0, 1'b1);
    accept(); tick();
    check_rank("retrig64_rank", 8'h4E);
    wait_to(t + 6);

    // Note-off 64, then a repeated (unmatched) note-off
    present(1'b0, 7'd64, t);
    expect_at(t + 2, "off64", full, 4'b1101, 1'b0, 1'b1);
    accept(); tick();
    check_rank("off64_rank", 8'h4E);

    present(1'b0, 7'd64, t);
    expect_at(t + 1, "off64_again_decide", full, 4'b1101, 1'b0, 1'b0);
    expect_at(t + 2, "off64_again", full, 4'b1101, 1'b0, 1'b1);
    accept(); tick();

    // Retrigger voice 2 and hit panic during its gap with an event pending
    present(1'b1, 7'd67, t);
    expect_at(t + 2, "retrig67_t2", full, 4'b1001, 1'b0, 1'b0);
    accept(); tick();
    check_rank("retrig67_rank", 8'h39);
    panic = 1'b1; ev_valid = 1'b1; ev_on = 1'b1; ev_note = 7'd50;
    p = cyc;
    expect_at(p + 1, "panic_p1", full, 4'b0000, 1'b0, 1'b0);
    expect_at(p + 3, "panic_p3", full, 4'b0000, 1'b0, 1'b0);
    tick(); tick(); tick();
    panic = 1'b0;
    t = cyc;
    expect_at(t + 1, "post_panic_decide", full, 4'b0000, 1'b0, 1'b0);
    expect_at(t + 2, "post_panic_on50", pk(7'd71, 7'd67, 7'd64, 7'd50), 4'b0001, 1'b0, 1'b1);
    accept(); tick();
    check_rank("on50_rank", 8'h27);

    // Reset while an event sits in DECIDE
    present(1'b1, 7'd55, t);
    accept();
    Reset = 1'b0;
    expect_at(t + 2, "reset_decide", 28'd0, 4'b0000, 1'b0, 1'b0);
    tick();
    check_rank("reset_decide_rank", 8'hE4);
    Reset = 1'b1;
    expect_at(t + 3, "reset_release", 28'd0, 4'b0000, 1'b0, 1'b1);
    tick();

    present(1'b1, 7'd40, t);
    expect_at(t + 2, "on40_after_reset", pk(7'd0, 7'd0, 7'd0, 7'd40), 4'b0001, 1'b0, 1'b1);
    accept(); tick();
    check_rank("on40_rank", 8'h93);

    tick(); tick();
    while (sb.size() > 0) begin
      n_cmp++; n_fail++;
      $display("FAIL %s left unchecked (due %0d)", sb[0].tag, sb[0].due);
      void'(sb.pop_front());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
